// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge detector.
// Optional build macro SOBEL_MAG_PIX_EN is consumed by sobel_edge_detect.
package sobel_pkg;

  localparam int DW_DEF   = 8;
  localparam int PIPE_LAT = 3;

  function automatic int mw_of(input int dw);
    return dw + 32'sd3;
  endfunction

  function automatic int sat_max(input int dw);
    return int'((32'd1 << dw) - 32'd1);
  endfunction

  localparam int MW_DEF  = mw_of(DW_DEF);
  localparam int SAT_MAX = sat_max(DW_DEF);

endpackage

// File: rtl/sobel_absdiff.sv
// Registered unsigned absolute difference |a-b|; larger minus smaller, so no
// signed arithmetic and no overflow.
module sobel_absdiff
  import sobel_pkg::*;
#(
  parameter int W = DW_DEF + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] y_d;
  logic [W-1:0] y_q;

  always_comb begin
    y_d = {W{1'b0}};
    if (a_i > b_i) begin
      y_d = a_i - b_i;
    end else begin
      y_d = b_i - a_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= {W{1'b0}};
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/sobel_edge_detect.sv
// Three-stage Sobel |Gx|+|Gy| with thresholded edge flag and display pixel.
// Build macro SOBEL_MAG_PIX_EN: pix_out carries the saturated magnitude instead of the edge flag.
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int MW = mw_of(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] p11,
  input  logic [DW-1:0] p12,
  input  logic [DW-1:0] p13,
  input  logic [DW-1:0] p21,
  input  logic [DW-1:0] p22,
  input  logic [DW-1:0] p23,
  input  logic [DW-1:0] p31,
  input  logic [DW-1:0] p32,
  input  logic [DW-1:0] p33,
  input  logic [MW-1:0] threshold,
  output logic          out_valid,
  output logic          edge_out,
  output logic [MW-1:0] mag_out,
  output logic [DW-1:0] pix_out
);

  localparam int SW = DW + 2;

  // Weighted 1-2-1 column/row sum; the centre tap is doubled by a shift.
  function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic [PIPE_LAT-1:0] valid_q;
  logic [SW-1:0] sxp_d, sxn_d, syp_d, syn_d;
  logic [SW-1:0] sxp_q, sxn_q, syp_q, syn_q;
  logic [SW-1:0] ax_q, ay_q;
  logic [MW-1:0] mag_d, mag_q;
  logic          edge_d, edge_q;
  logic [DW-1:0] pix_d, pix_q;

  always_comb begin
    sxp_d = wsum(p13, p23, p33);
    sxn_d = wsum(p11, p21, p31);
    syp_d = wsum(p31, p32, p33);
    syn_d = wsum(p11, p12, p13);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {PIPE_LAT{1'b0}};
      sxp_q   <= {SW{1'b0}};
      sxn_q   <= {SW{1'b0}};
      syp_q   <= {SW{1'b0}};
      syn_q   <= {SW{1'b0}};
    end else begin
      valid_q <= {valid_q[PIPE_LAT-2:0], in_valid};
      sxp_q   <= sxp_d;
      sxn_q   <= sxn_d;
      syp_q   <= syp_d;
      syn_q   <= syn_d;
    end
  end

  sobel_absdiff #(.W(SW)) u_ax (
    .clk (clk),
    .rst (rst),
    .a_i (sxp_q),
    .b_i (sxn_q),
    .y_o (ax_q)
  );

  sobel_absdiff #(.W(SW)) u_ay (
    .clk (clk),
    .rst (rst),
    .a_i (syp_q),
    .b_i (syn_q),
    .y_o (ay_q)
  );

  // Threshold is used live here, so a change applies to the very next result.
  always_comb begin
    mag_d  = MW'(ax_q) + MW'(ay_q);
    edge_d = (mag_d > threshold);
`ifdef SOBEL_MAG_PIX_EN
    if (mag_d > MW'(sat_max(DW))) begin
      pix_d = DW'(sat_max(DW));
    end else begin
      pix_d = mag_d[DW-1:0];
    end
`else
    if (edge_d) begin
      pix_d = DW'(sat_max(DW));
    end else begin
      pix_d = {DW{1'b0}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q  <= {MW{1'b0}};
      edge_q <= 1'b0;
      pix_q  <= {DW{1'b0}};
    end else begin
      mag_q  <= mag_d;
      edge_q <= edge_d;
      pix_q  <= pix_d;
    end
  end

  assign out_valid = valid_q[PIPE_LAT-1];
  assign edge_out  = edge_q;
  assign mag_out   = mag_q;
  assign pix_out   = pix_q;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Bench for sobel_edge_detect: kernel-based reference model checked every cycle
// plus literal expectations for the hand-worked windows.
module tb_sobel_edge_detect;
  import sobel_pkg::*;

  localparam int DW = 8;
  localparam int MW = 11;

  typedef logic [8:0][7:0] win_t;  // index 0 = p11 ... index 8 = p33

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [MW-1:0] threshold;
  logic          out_valid, edge_out;
  logic [MW-1:0] mag_out;
  logic [DW-1:0] pix_out;

  always #5 clk = ~clk;

  sobel_edge_detect #(.DW(DW), .MW(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33),
    .threshold(threshold), .out_valid(out_valid), .edge_out(edge_out),
    .mag_out(mag_out), .pix_out(pix_out)
  );

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  win_t cur_w;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: Sobel kernels applied directly, result delayed, threshold applied last.
  int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  function automatic int grad_mag(input win_t w);
    int gx = 0;
    int gy = 0;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * int'(w[i]);
      gy += ky[i] * int'(w[i]);
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return gx + gy;
  endfunction

  int slot_v[2] = '{0, 0};
  int slot_m[2] = '{0, 0};
  int exp_valid = 0, exp_mag = 0, exp_edge = 0, exp_pix = 0;

  always @(posedge clk) begin
    if (rst) begin
      slot_v = '{0, 0};
      slot_m = '{0, 0};
      exp_valid = 0; exp_mag = 0; exp_edge = 0; exp_pix = 0;
    end else begin
      exp_valid = slot_v[1];
      exp_mag   = slot_m[1];
      exp_edge  = (exp_mag > int'(threshold)) ? 1 : 0;
`ifdef SOBEL_MAG_PIX_EN
      exp_pix   = (exp_mag > SAT_MAX) ? SAT_MAX : exp_mag;
`else
      exp_pix   = exp_edge ? SAT_MAX : 0;
`endif
      slot_v[1] = slot_v[0];
      slot_m[1] = slot_m[0];
      slot_v[0] = in_valid ? 1 : 0;
      slot_m[0] = grad_mag(cur_w);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_valid", out_valid, exp_valid);
      check("model_mag_out", mag_out, exp_mag);
      check("model_edge_out", edge_out, exp_edge);
      check("model_pix_out", pix_out, exp_pix);
    end
  end

  function automatic win_t mk(input int a11, a12, a13, a21, a22, a23, a31, a32, a33);
    return {8'(a33), 8'(a32), 8'(a31), 8'(a23), 8'(a22), 8'(a21), 8'(a13), 8'(a12), 8'(a11)};
  endfunction

  task automatic drive(input logic v, input win_t w, input logic [MW-1:0] t);
    @(negedge clk);
    in_valid  = v;
    cur_w     = w;
    {p33, p32, p31, p23, p22, p21, p13, p12, p11} = w;
    threshold = t;
  endtask

  // One window followed by two bubbles; result checked three clocks after it was presented.
  task automatic one(input string nm, input win_t w, input logic [MW-1:0] t,
                     input int em, input int ee, input int ep_bin, input int ep_sat);
    drive(1'b1, w, t);
    drive(1'b0, '0, t);
    drive(1'b0, '0, t);
    @(negedge clk);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_mag"}, mag_out, em);
    check({nm, "_edge"}, edge_out, ee);
`ifdef SOBEL_MAG_PIX_EN
    check({nm, "_pix"}, pix_out, ep_sat);
`else
    check({nm, "_pix"}, pix_out, ep_bin);
`endif
  endtask

  win_t flat, vert, horz, maxw, tiny;
  logic [4:0] ov;
  int pat[5] = '{1, 0, 1, 1, 0};

  initial begin
    flat = mk(100, 100, 100, 100, 100, 100, 100, 100, 100);
    vert = mk(0, 0, 255, 0, 0, 255, 0, 0, 255);
    horz = mk(0, 0, 0, 0, 0, 0, 255, 255, 255);
    // Gx = 0+510+255 = 765, Gy = 0+510+255 = 765 -> 1530
    maxw = mk(0, 0, 0, 0, 255, 255, 0, 255, 255);
    tiny = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);  // Gx = 2, Gy = 0

    rst = 1'b1; in_valid = 1'b0; threshold = '0; cur_w = '0;
    {p33, p32, p31, p23, p22, p21, p13, p12, p11} = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_mag", mag_out, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    one("flat", flat, 11'd0, 0, 0, 0, 0);
    one("vert", vert, 11'd500, 1020, 1, 255, 255);
    one("horz_eq", horz, 11'd1020, 1020, 0, 0, 255);
    one("horz_below", horz, 11'd1019, 1020, 1, 255, 255);
    one("max_thr_max", maxw, 11'd2047, 1530, 0, 0, 255);
    one("max_thr500", maxw, 11'd500, 1530, 1, 255, 255);
    one("tiny_thr0", tiny, 11'd0, 2, 1, 255, 2);

    // Threshold is taken in the cycle the result is formed, two clocks after the window.
    drive(1'b1, horz, 11'd1020);
    drive(1'b0, '0, 11'd1020);
    drive(1'b0, '0, 11'd1019);
    @(negedge clk);
    check("thr_late_edge", edge_out, 1);

    // Valid pattern 1,0,1,1,0 with distinct windows, back to back.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3) ov[i-3] = out_valid;
      in_valid  = (i < 5) ? pat[i][0] : 1'b0;
      cur_w     = mk(i * 10, i * 20, 30 + i, 5, 7, 200 - i * 15, 9 + i, 60, 90 + i * 30);
      {p33, p32, p31, p23, p22, p21, p13, p12, p11} = cur_w;
      threshold = 11'd300;
    end
    check("valid_pattern", {27'd0, ov}, {27'd0, 5'b01101});

    // Reset with windows in flight: nothing stale may emerge afterwards.
    drive(1'b1, vert, 11'd500);
    drive(1'b1, horz, 11'd500);
    drive(1'b1, maxw, 11'd500);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_mag", mag_out, 0);
    check("rst_mid_edge", edge_out, 0);
    check("rst_mid_pix", pix_out, 0);
    rst = 1'b0;
    in_valid = 1'b1; cur_w = vert;
    {p33, p32, p31, p23, p22, p21, p13, p12, p11} = vert;
    drive(1'b0, '0, 11'd500);
    check("post_rst_gap1", out_valid, 0);
    drive(1'b0, '0, 11'd500);
    check("post_rst_gap2", out_valid, 0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_mag", mag_out, 1020);
    check("post_rst_edge", edge_out, 1);

    repeat (3) drive(1'b0, '0, 11'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
